// File: rtl/stream_to_enable.sv
// Valid/ready stream into a DEPTH-entry FIFO, drained one word per tick as an
// enable-qualified, held output word. Empty ticks raise a saturating underrun count.
module stream_to_enable #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         tick,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_en,
  output logic                         underrun,
  output logic [15:0]                  underrun_count,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]               level_q, level_d;
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic                        out_en_q, out_en_d;
  logic                        underrun_q, underrun_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        wr, rd, urun;

  // Ready depends only on registered occupancy, never on in_valid.
  assign in_ready = (level_q != FULL);

  // Reads look only at registered level, so a word written this cycle into
  // an empty FIFO cannot be popped until the next tick.
  always_comb begin
    wr   = in_valid && in_ready && !flush;
    rd   = tick && (level_q != '0) && !flush;
    urun = tick && (level_q == '0) && !flush;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    out_data_d = out_data_q;
    out_en_d   = rd;
    underrun_d = urun;
    cnt_d      = cnt_q;

    if (wr) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd) begin
      out_data_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end
    case ({wr, rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (urun && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      out_en_q   <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_en         = out_en_q;
  assign underrun       = underrun_q;
  assign underrun_count = cnt_q;
  assign level          = level_q;
endmodule

// File: tb/tb_stream_to_enable.sv
// Directed bench for stream_to_enable at WIDTH=8, DEPTH=4; inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_stream_to_enable;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_en, underrun;
  logic [7:0] out_data;
  logic [15:0] underrun_count;
  logic [2:0] level;
  int n_run = 0, n_fail = 0;

  stream_to_enable #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_en(out_en), .underrun(underrun),
    .underrun_count(underrun_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst_ready", in_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_en", out_en, 0);
    chk("rst_data", out_data, 0);
    chk("rst_urun", underrun, 0);
    chk("rst_cnt", underrun_count, 0);
    reset_n = 1'b1;

    // basic stream
    in_valid = 1; in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_data = 8'h33; cyc();
    in_valid = 0;
    chk("bas_level", level, 3);
    begin
      logic [7:0] exp_w [3];
      exp_w = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
        tick = 1; cyc(); tick = 0;
        chk("bas_en", out_en, 1);
        chk("bas_data", out_data, exp_w[i]);
        cyc();
        chk("bas_en_low", out_en, 0);
        chk("bas_hold", out_data, exp_w[i]);
        cyc();
      end
    end
    chk("bas_final", out_data, 8'h33);
    chk("bas_cnt", underrun_count, 0);
    chk("bas_empty", level, 0);

    // full backpressure
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      chk("full_rdy_pre", in_ready, 1);
      in_data = 8'(k); cyc();
    end
    chk("full_level", level, 4);
    chk("full_rdy", in_ready, 0);
    in_data = 8'd4; cyc();
    chk("full_hold", level, 4);
    tick = 1; cyc(); tick = 0;
    chk("full_en", out_en, 1);
    chk("full_w0", out_data, 0);
    chk("full_lvl3", level, 3);
    chk("full_rdy_back", in_ready, 1);
    cyc(); in_valid = 0;
    chk("full_lvl4b", level, 4);
    tick = 1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("full_en_d", out_en, 1);
      chk("full_seq", out_data, k);
    end
    tick = 0; cyc();
    chk("full_drained", level, 0);
    chk("full_cnt", underrun_count, 0);

    // underrun
    tick = 1; cyc();
    chk("ur1", underrun, 1);
    chk("ur1_en", out_en, 0);
    cyc();
    chk("ur2", underrun, 1);
    in_valid = 1; in_data = 8'hA5; cyc();
    tick = 0; in_valid = 0;
    chk("ur3", underrun, 1);
    chk("ur3_en", out_en, 0);
    chk("ur_cnt", underrun_count, 3);
    chk("ur_lvl", level, 1);
    chk("ur_hold", out_data, 4);
    tick = 1; cyc(); tick = 0;
    chk("ur4_en", out_en, 1);
    chk("ur4_data", out_data, 8'hA5);
    chk("ur4_nourun", underrun, 0);
    chk("ur4_cnt", underrun_count, 3);

    // flush
    in_valid = 1;
    in_data = 8'hB1; cyc();
    in_data = 8'hB2; cyc();
    in_data = 8'hB3; cyc();
    chk("fl_pre", level, 3);
    flush = 1; tick = 1; in_data = 8'hC4; cyc();
    flush = 0; tick = 0; in_valid = 0;
    chk("fl_en", out_en, 0);
    chk("fl_urun", underrun, 0);
    chk("fl_lvl", level, 0);
    chk("fl_data", out_data, 8'hA5);
    chk("fl_cnt", underrun_count, 3);
    tick = 1; cyc(); tick = 0;
    chk("fl_dropped", underrun, 1);
    chk("fl_dropped_en", out_en, 0);
    chk("fl_cnt4", underrun_count, 4);

    // saturation: 4 + 65540 would wrap past 16'hFFFF
    tick = 1;
    for (int k = 0; k < 65540; k++) cyc();
    chk("sat_cnt", underrun_count, 16'hFFFF);
    chk("sat_urun", underrun, 1);
    cyc();
    chk("sat_cnt2", underrun_count, 16'hFFFF);
    chk("sat_urun2", underrun, 1);
    tick = 0;

    // async reset mid-burst
    in_valid = 1;
    in_data = 8'hD1; cyc();
    in_data = 8'hD2; cyc();
    in_valid = 0;
    chk("ar_lvl2", level, 2);
    #2 reset_n = 0;
    #1;
    chk("ar_lvl", level, 0);
    chk("ar_data", out_data, 0);
    chk("ar_cnt", underrun_count, 0);
    chk("ar_rdy", in_ready, 1);
    chk("ar_urun", underrun, 0);
    chk("ar_en", out_en, 0);
    #2 reset_n = 1;
    tick = 1; cyc(); tick = 0;
    chk("ar_post_urun", underrun, 1);
    chk("ar_post_en", out_en, 0);
    chk("ar_post_cnt", underrun_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
